// File: rtl/branch_q.sv
// Branch resolution unit: compares operands one cycle after issue, returns the
// link value to writeback and queues mispredict redirects for commit.
module branch_q #(
    parameter int RV         = 64,
    parameter int NHART      = 1,
    parameter int LNHART     = 1,
    parameter int BDEC       = 4,
    parameter int NCOMMIT    = 32,
    parameter int LNCOMMIT   = 5,
    parameter int DEPTH      = 4,
    parameter int LDEPTH     = 2,
    parameter int CNTRL_SIZE = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CNTRL_SIZE-1:0] control,
    input  logic [LNHART-1:0]     hart,
    input  logic [RV-1:0]         r1,
    input  logic [RV-1:0]         r2,
    input  logic [31:0]           immed,
    input  logic [RV-2:0]         pc,
    input  logic [RV-2:0]         branch_dest,
    input  logic [LNCOMMIT-1:0]   rd,
    input  logic                  makes_rd,
    input  logic [NCOMMIT-1:0]    commit_kill,
    output logic                  busy,
    output logic [LNCOMMIT-1:0]   res_rd,
    output logic [NHART-1:0]      res_makes_rd,
    output logic [RV-1:0]         result,
    output logic                  commit_br_valid,
    input  logic                  commit_br_ready,
    output logic [RV-2:0]         commit_br,
    output logic [LNCOMMIT-1:0]   commit_br_addr,
    output logic [LNHART-1:0]     commit_br_hart,
    output logic                  commit_br_short,
    output logic [BDEC-2:0]       commit_br_dec,
    output logic                  overflow
);
    localparam logic [LDEPTH:0]   C_FULL = (LDEPTH+1)'(DEPTH);
    localparam logic [LDEPTH+1:0] C_BUSY = (LDEPTH+2)'(DEPTH-1);

    // Stage A
    logic                r_a_valid, r_pred, r_short, r_inv, r_cjmp, r_a_makes_rd;
    logic [1:0]          r_type;
    logic [RV-2:0]       r_a_pc, r_a_dest;
    logic [31:0]         r_a_imm;
    logic [LNCOMMIT-1:0] r_a_rd;
    logic [LNHART-1:0]   r_a_hart;

    // Stage B / status
    logic                r_busy, r_overflow;
    logic [RV-1:0]       r_result;
    logic [LNCOMMIT-1:0] r_res_rd;
    logic [NHART-1:0]    r_res_makes_rd;

    // Redirect FIFO
    logic [DEPTH-1:0]    r_q_vld;
    logic [RV-2:0]       r_q_tgt  [DEPTH];
    logic [LNCOMMIT-1:0] r_q_rd   [DEPTH];
    logic [LNHART-1:0]   r_q_hart [DEPTH];
    logic                r_q_sh   [DEPTH];
    logic [BDEC-2:0]     r_q_dec  [DEPTH];
    logic [LDEPTH-1:0]   r_wr_ptr, r_rd_ptr;
    logic [LDEPTH:0]     r_count;

    logic          w_need, w_mispred, w_push, w_pop, w_disc, w_deq, w_acc, w_full;
    logic [RV-1:0] w_imm_ext, w_jr;
    logic [RV-2:0] w_pc_seq, w_pc_imm, w_target;
    logic          w_unused;

    assign w_imm_ext = RV'($signed(r_a_imm));
    assign w_pc_seq  = r_a_pc + {{(RV-3){1'b0}}, ~r_short, r_short};
    assign w_pc_imm  = r_a_pc + w_imm_ext[RV-2:0];
    assign w_jr      = r1 + w_imm_ext;
    assign w_unused  = &{1'b0, control[CNTRL_SIZE-1:6], w_jr[0]};

    always_comb begin
        w_need = (r1 == r2);
        case (r_type)
            2'd2:    w_need = ($signed(r1) < $signed(r2));
            2'd3:    w_need = (r1 < r2);
            default: w_need = (r1 == r2);
        endcase
    end

    // Conditional: the XOR is true exactly when the prediction was wrong, and
    // the redirect goes to whichever path was not predicted.
    always_comb begin
        w_mispred = 1'b0;
        w_target  = w_pc_imm;
        if (r_cjmp) begin
            w_mispred = r_pred ^ r_inv ^ w_need;
            w_target  = r_pred ? w_pc_seq : w_pc_imm;
        end else if (!r_type[0]) begin
            w_mispred = !r_pred || (w_jr[RV-1:1] != r_a_dest);
            w_target  = w_jr[RV-1:1];
        end
    end

    assign commit_br_valid = (r_count != '0) && r_q_vld[r_rd_ptr] && !commit_kill[r_q_rd[r_rd_ptr]];
    assign w_pop  = commit_br_valid & commit_br_ready;
    assign w_disc = (r_count != '0) && !r_q_vld[r_rd_ptr];
    assign w_deq  = w_pop | w_disc;
    assign w_push = r_a_valid & w_mispred & !commit_kill[r_a_rd];
    assign w_full = (r_count == C_FULL);
    // A dequeue in the same cycle frees the slot the push lands in, even when full.
    assign w_acc  = w_push & (!w_full | w_deq);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_valid      <= 1'b0;
            r_pred         <= 1'b0;
            r_short        <= 1'b0;
            r_inv          <= 1'b0;
            r_cjmp         <= 1'b0;
            r_type         <= '0;
            r_a_makes_rd   <= 1'b0;
            r_a_pc         <= '0;
            r_a_dest       <= '0;
            r_a_imm        <= '0;
            r_a_rd         <= '0;
            r_a_hart       <= '0;
            r_busy         <= 1'b0;
            r_overflow     <= 1'b0;
            r_result       <= '0;
            r_res_rd       <= '0;
            r_res_makes_rd <= '0;
            r_q_vld        <= '0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_tgt[i]  <= '0;
                r_q_rd[i]   <= '0;
                r_q_hart[i] <= '0;
                r_q_sh[i]   <= 1'b0;
                r_q_dec[i]  <= '0;
            end
        end else begin
            r_a_valid    <= enable & !commit_kill[rd];
            r_pred       <= control[5];
            r_short      <= control[4];
            r_inv        <= control[3];
            r_type       <= control[2:1];
            r_cjmp       <= control[0];
            r_a_makes_rd <= makes_rd;
            r_a_pc       <= pc;
            r_a_dest     <= branch_dest;
            r_a_imm      <= immed;
            r_a_rd       <= rd;
            r_a_hart     <= hart;

            // Counts the op in stage A so the issue already in flight still fits.
            r_busy <= ({1'b0, r_count} + {{(LDEPTH+1){1'b0}}, r_a_valid}) >= C_BUSY;

            if (r_a_valid) begin
                r_result <= {w_pc_seq, 1'b0};
                r_res_rd <= r_a_rd;
            end
            r_res_makes_rd <= (r_a_valid & r_a_makes_rd) ? (NHART'(1) << r_a_hart) : '0;

            for (int i = 0; i < DEPTH; i++)
                if (r_q_vld[i] && commit_kill[r_q_rd[i]]) r_q_vld[i] <= 1'b0;

            if (w_deq) begin
                r_q_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + LDEPTH'(1);
            end
            if (w_acc) begin
                r_q_vld[r_wr_ptr]  <= 1'b1;
                r_q_tgt[r_wr_ptr]  <= w_target;
                r_q_rd[r_wr_ptr]   <= r_a_rd;
                r_q_hart[r_wr_ptr] <= r_a_hart;
                r_q_sh[r_wr_ptr]   <= r_short;
                r_q_dec[r_wr_ptr]  <= r_a_pc[BDEC-2:0];
                r_wr_ptr           <= r_wr_ptr + LDEPTH'(1);
            end
            if (w_push && !w_acc) r_overflow <= 1'b1;

            r_count <= r_count + {{LDEPTH{1'b0}}, w_acc} - {{LDEPTH{1'b0}}, w_deq};
        end
    end

    assign busy            = r_busy;
    assign overflow        = r_overflow;
    assign result          = r_result;
    assign res_rd          = r_res_rd;
    assign res_makes_rd    = r_res_makes_rd;
    assign commit_br       = r_q_tgt[r_rd_ptr];
    assign commit_br_addr  = r_q_rd[r_rd_ptr];
    assign commit_br_hart  = r_q_hart[r_rd_ptr];
    assign commit_br_short = r_q_sh[r_rd_ptr];
    assign commit_br_dec   = r_q_dec[r_rd_ptr];
endmodule

// File: tb/tb_branch_q.sv
// Bench for branch_q: vector table for single branches, scoreboard for the
// redirect FIFO, hand sequences for fill/overflow, kill and mid-queue reset.
module tb_branch_q;
    logic        clk = 0, reset = 1, enable = 0, makes_rd = 0, commit_br_ready = 0;
    logic [6:0]  control = 0;
    logic        hart = 0;
    logic [63:0] r1 = 0, r2 = 0;
    logic [31:0] immed = 0;
    logic [62:0] pc = 0, branch_dest = 0;
    logic [4:0]  rd = 0;
    logic [31:0] commit_kill = 0;
    logic        busy, commit_br_valid, commit_br_short, overflow, commit_br_hart;
    logic [4:0]  res_rd, commit_br_addr;
    logic [1:0]  res_makes_rd;
    logic [63:0] result;
    logic [62:0] commit_br;
    logic [2:0]  commit_br_dec;

    branch_q #(.NHART(2), .LNHART(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .control(control), .hart(hart),
        .r1(r1), .r2(r2), .immed(immed), .pc(pc), .branch_dest(branch_dest), .rd(rd),
        .makes_rd(makes_rd), .commit_kill(commit_kill), .busy(busy), .res_rd(res_rd),
        .res_makes_rd(res_makes_rd), .result(result), .commit_br_valid(commit_br_valid),
        .commit_br_ready(commit_br_ready), .commit_br(commit_br), .commit_br_addr(commit_br_addr),
        .commit_br_hart(commit_br_hart), .commit_br_short(commit_br_short),
        .commit_br_dec(commit_br_dec), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctrl;
        logic [63:0] a, b;
        logic [31:0] imm;
        logic [62:0] p, dest;
        logic [4:0]  r;
        logic        h, mk;
        logic        exp_redir;
        logic [62:0] exp_tgt;
        logic [63:0] exp_res;
        logic [1:0]  exp_mk;
    } vec_t;

    typedef struct {
        logic [62:0] tgt;
        logic [4:0]  r;
        logic        h, sh;
        logic [2:0]  dec;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0, n_errors = 0;
    vec_t vt[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [6:0] c, input logic [31:0] im, input logic [62:0] p,
                         input logic [62:0] d, input logic [4:0] r, input logic h, input logic m);
        enable = 1; control = c; immed = im; pc = p; branch_dest = d; rd = r; hart = h; makes_rd = m;
    endtask

    task automatic sb_add(input logic [62:0] t, input logic [4:0] r, input logic h,
                          input logic sh, input logic [62:0] p);
        sb_t e;
        e.tgt = t; e.r = r; e.h = h; e.sh = sh; e.dec = p[2:0];
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every accepted redirect must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && commit_br_valid && commit_br_ready) begin
            if (sb.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL sb_unexpected: got addr %0h expected no redirect", commit_br_addr);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("br_tgt",   64'(commit_br),       64'(e.tgt));
                chk("br_addr",  64'(commit_br_addr),  64'(e.r));
                chk("br_hart",  64'(commit_br_hart),  64'(e.h));
                chk("br_short", 64'(commit_br_short), 64'(e.sh));
                chk("br_dec",   64'(commit_br_dec),   64'(e.dec));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        //          ctrl   r1                r2     imm           pc       dest     rd  h  mk  redir tgt          result    mk
        vt[0]  = '{7'h21, 64'd5,            64'd5, 32'h0,        63'h800, 63'h0,    5'd1, 0, 1, 0, 63'h0,        64'h1004, 2'b01};
        vt[1]  = '{7'h07, 64'd1,            64'd2, 32'h40,       63'h1000,63'h0,    5'd4, 0, 0, 1, 63'h1040,     64'h2004, 2'b00};
        vt[2]  = '{7'h20, 64'h3000,         64'd0, 32'h8,        63'h100, 63'h1804, 5'd2, 1, 1, 0, 63'h0,        64'h204,  2'b10};
        vt[3]  = '{7'h20, 64'h3000,         64'd0, 32'h8,        63'h105, 63'h1800, 5'd5, 1, 1, 1, 63'h1804,     64'h20E,  2'b10};
        vt[4]  = '{7'h15, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'hFFFF_FFF0, 63'h2000, 63'h0, 5'd6, 0, 0, 1, 63'h1FF0, 64'h4002, 2'b00};
        vt[5]  = '{7'h07, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h40, 63'h30, 63'h0,   5'd7, 1, 0, 0, 63'h0,        64'h64,   2'b00};
        vt[6]  = '{7'h29, 64'd3,            64'd3, 32'h100,      63'h400, 63'h0,    5'd8, 1, 1, 1, 63'h402,      64'h804,  2'b10};
        vt[7]  = '{7'h02, 64'd0,            64'd0, 32'h20,       63'h10,  63'h999,  5'd9, 0, 1, 0, 63'h0,        64'h24,   2'b01};
        vt[8]  = '{7'h10, 64'h3000,         64'd0, 32'h8,        63'h203, 63'h1804, 5'd10,0, 0, 1, 63'h1804,     64'h408,  2'b00};
        vt[9]  = '{7'h20, 64'h1_0000_0000,  64'd0, 32'hFFFF_FFFC,63'h50,  63'h0,    5'd11,0, 1, 1, 63'h7FFF_FFFE,64'hA4,   2'b01};
        vt[10] = '{7'h21, 64'd5,            64'd6, 32'h0,        63'h7F0, 63'h0,    5'd3, 0, 0, 1, 63'h7F2,      64'hFE4,  2'b00};
        vt[11] = '{7'h05, 64'd1,  64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 63'h60, 63'h0,    5'd13,1, 1, 0, 63'h0,        64'hC4,   2'b10};

        step(); step();
        chk("rst_busy",   64'(busy),            64'd0);
        chk("rst_valid",  64'(commit_br_valid), 64'd0);
        chk("rst_ovf",    64'(overflow),        64'd0);
        chk("rst_result", result,               64'd0);
        chk("rst_mk",     64'(res_makes_rd),    64'd0);
        reset = 0;
        commit_br_ready = 1;
        step();

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].ctrl, vt[i].imm, vt[i].p, vt[i].dest, vt[i].r, vt[i].h, vt[i].mk);
            if (vt[i].exp_redir) sb_add(vt[i].exp_tgt, vt[i].r, vt[i].h, vt[i].ctrl[4], vt[i].p);
            step();
            enable = 0; r1 = vt[i].a; r2 = vt[i].b;
            step();
            chk($sformatf("v%0d_result", i), result,               vt[i].exp_res);
            chk($sformatf("v%0d_res_rd", i), 64'(res_rd),          64'(vt[i].r));
            chk($sformatf("v%0d_mk", i),     64'(res_makes_rd),    64'(vt[i].exp_mk));
            chk($sformatf("v%0d_valid", i),  64'(commit_br_valid), 64'(vt[i].exp_redir));
            step(); step();
        end
        drain("vec_drain");

        // Kill at issue and kill while in stage A: neither may queue.
        r1 = 1; r2 = 2;
        drive(7'h07, 32'h40, 63'h500, 63'h0, 5'd12, 0, 1);
        commit_kill = 32'h1 << 12;
        step();
        enable = 0; commit_kill = 0;
        step();
        chk("kill_issue_valid", 64'(commit_br_valid), 64'd0);
        chk("kill_issue_mk",    64'(res_makes_rd),    64'd0);
        drive(7'h07, 32'h40, 63'h500, 63'h0, 5'd13, 0, 1);
        step();
        enable = 0; commit_kill = 32'h1 << 13;
        step();
        commit_kill = 0;
        chk("kill_a_valid", 64'(commit_br_valid), 64'd0);
        chk("kill_a_mk",    64'(res_makes_rd),    64'd1);
        step();

        // Fill with commit stalled; watch busy rise, then force an overflow.
        commit_br_ready = 0; r1 = 1; r2 = 2;
        for (int i = 0; i < 4; i++) begin
            drive(7'h07, 32'h40, 63'h100 + 63'(i), 63'h0, 5'(20 + i), 0, 0);
            sb_add(63'h140 + 63'(i), 5'(20 + i), 0, 0, 63'h100 + 63'(i));
            if (i == 3) chk("busy_low_c3", 64'(busy), 64'd0);
            step();
        end
        enable = 0;
        chk("busy_rise", 64'(busy), 64'd1);
        step();
        chk("full_ovf0",  64'(overflow),        64'd0);
        chk("full_valid", 64'(commit_br_valid), 64'd1);
        chk("full_head",  64'(commit_br_addr),  64'd20);
        drive(7'h07, 32'h40, 63'h200, 63'h0, 5'd24, 0, 0);
        step();
        enable = 0;
        step();
        chk("ovf_set",  64'(overflow),       64'd1);
        chk("ovf_head", 64'(commit_br_addr), 64'd20);
        chk("ovf_busy", 64'(busy),           64'd1);
        // Push at full with a simultaneous pop is accepted.
        drive(7'h07, 32'h40, 63'h204, 63'h0, 5'd25, 1, 0);
        sb_add(63'h244, 5'd25, 1, 0, 63'h204);
        step();
        enable = 0; commit_br_ready = 1;
        step();
        chk("fullpp_head", 64'(commit_br_addr), 64'd21);
        drain("fill_drain");
        chk("ovf_sticky", 64'(overflow), 64'd1);
        step();

        // Kill a queued middle entry; commit must see 3 then 9.
        commit_br_ready = 0;
        drive(7'h07, 32'h40, 63'h600, 63'h0, 5'd3, 0, 0); sb_add(63'h640, 5'd3, 0, 0, 63'h600); step();
        drive(7'h07, 32'h40, 63'h601, 63'h0, 5'd7, 0, 0); step();
        drive(7'h07, 32'h40, 63'h602, 63'h0, 5'd9, 1, 0); sb_add(63'h642, 5'd9, 1, 0, 63'h602); step();
        enable = 0; step(); step();
        chk("kq_head", 64'(commit_br_addr), 64'd3);
        commit_kill = 32'h1 << 7;
        step();
        commit_kill = 0;
        commit_br_ready = 1;
        drain("kill_drain");
        step();
        chk("kill_empty", 64'(commit_br_valid), 64'd0);

        // Reset with two queued redirects and one in stage A.
        commit_br_ready = 0;
        drive(7'h07, 32'h40, 63'h300, 63'h0, 5'd14, 1, 1); step();
        drive(7'h07, 32'h40, 63'h301, 63'h0, 5'd15, 1, 1); step();
        drive(7'h07, 32'h40, 63'h302, 63'h0, 5'd16, 1, 1); step();
        enable = 0;
        chk("pre_rst_valid", 64'(commit_br_valid), 64'd1);
        reset = 1;
        step();
        chk("mrst_valid",  64'(commit_br_valid), 64'd0);
        chk("mrst_ovf",    64'(overflow),        64'd0);
        chk("mrst_busy",   64'(busy),            64'd0);
        chk("mrst_result", result,               64'd0);
        chk("mrst_res_rd", 64'(res_rd),          64'd0);
        chk("mrst_mk",     64'(res_makes_rd),    64'd0);
        chk("mrst_br",     64'(commit_br),       64'd0);
        chk("mrst_addr",   64'(commit_br_addr),  64'd0);
        chk("mrst_hart",   64'(commit_br_hart),  64'd0);
        reset = 0;
        step(); step(); step();
        chk("post_rst_valid", 64'(commit_br_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
